// File: rtl/div_seq_pkg.sv
// Shared ALU op codes and divider state encoding for the EX-stage DIV/DIVU path.
package div_seq_pkg;

    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    // One extra bit: the shifted remainder can reach 2*divisor-1.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted  = {rem, dvd_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign qbit     = (shifted >= {1'b0, divisor});
    assign rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: stalls the pipeline while a 32-step restoring divide runs,
// then holds quotient (lo) and remainder (hi) until the EX stage advances.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ack_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    div_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] dvd_reg;   // remaining dividend bits, quotient bits shift in from the bottom
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             qneg_reg;
    logic             rneg_reg;
    logic             bzero_reg;

    logic             req;
    logic             is_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] rem_next;
    logic             qbit;
    logic [WIDTH-1:0] q_final;

    assign req       = is_div_op(op_i);
    assign is_signed = (op_i == EXE_DIV_OP);
    assign a_abs     = (is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs     = (is_signed && b_i[WIDTH-1]) ? -b_i : b_i;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .dvd_bit  (dvd_reg[WIDTH-1]),
        .divisor  (dvs_reg),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    assign q_final = {dvd_reg[WIDTH-2:0], qbit};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= DIV_IDLE;
            cnt_reg   <= '0;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            rem_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            qneg_reg  <= 1'b0;
            rneg_reg  <= 1'b0;
            bzero_reg <= 1'b0;
        end else if (flush_i) begin
            state_reg <= DIV_IDLE;
        end else begin
            case (state_reg)
                DIV_IDLE: begin
                    if (req) begin
                        dvd_reg   <= a_abs;
                        dvs_reg   <= b_abs;
                        qneg_reg  <= is_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        rneg_reg  <= is_signed && a_i[WIDTH-1];
                        bzero_reg <= (b_i == '0);
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    dvd_reg <= q_final;
                    rem_reg <= rem_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        state_reg <= DIV_DONE;
                        lo_reg    <= bzero_reg ? '1 : (qneg_reg ? -q_final : q_final);
                        // With a zero divisor the remainder ends as |a|, so the sign fix restores a.
                        hi_reg    <= rneg_reg ? -rem_next : rem_next;
                    end
                end
                DIV_DONE: begin
                    if (ack_i) begin
                        state_reg <= DIV_IDLE;
                    end
                end
                default: state_reg <= DIV_IDLE;
            endcase
        end
    end

    assign stall_o = ((state_reg == DIV_IDLE) && req && !flush_i) || (state_reg == DIV_BUSY);
    assign valid_o = (state_reg == DIV_DONE);
    assign hi_o    = hi_reg;
    assign lo_o    = lo_reg;

endmodule

// File: tb/tb_div_seq.sv
// Randomized and directed bench for div_seq with a queue-based scoreboard and arithmetic reference model.
module tb_div_seq;
    import div_seq_pkg::*;

    localparam logic [7:0] NOP_OP = 8'h00;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  op_i = NOP_OP;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        ack_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    div_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .ack_i   (ack_i),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .valid_o (valid_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics (truncating division), zero divisor gives lo=all ones, hi=a.
    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == EXE_DIV_OP) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Monitor: every new result presented by the DUT is compared against the scoreboard front.
    initial begin
        logic        valid_prev;
        logic [63:0] e;
        valid_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_o && !valid_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("lo", lo_o, e[31:0]);
                    check("hi", hi_o, e[63:32]);
                    $display("result: lo=0x%08h hi=0x%08h", lo_o, hi_o);
                end
            end
            valid_prev = valid_o;
        end
    end

    task automatic start(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        op_i = op;
        a_i  = a;
        b_i  = b;
    endtask

    task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [63:0] e;
        int cyc, stall_cnt;
        bit got;
        e = model(op, a, b);
        exp_q.push_back(e);
        $display("issue: op=0x%02h a=0x%08h b=0x%08h hold=%0d", op, a, b, hold);
        start(op, a, b);
        cyc = 0; stall_cnt = 0; got = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (valid_o) got = 1;
            else begin
                if (stall_o) stall_cnt++;
                cyc++;
            end
        end
        check("latency", cyc, 33);
        check("stall_cycles", stall_cnt, 33);
        if (got) begin
            check("stall_in_done", {31'd0, stall_o}, 32'd0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_valid", {31'd0, valid_o}, 32'd1);
                check("hold_lo", lo_o, e[31:0]);
                check("hold_hi", hi_o, e[63:32]);
            end
            @(posedge clk); #1; ack_i = 1'b1;
            @(posedge clk); #1; ack_i = 1'b0; op_i = NOP_OP;
            @(negedge clk);
            check("idle_valid", {31'd0, valid_o}, 32'd0);
            check("idle_stall", {31'd0, stall_o}, 32'd0);
        end else begin
            op_i = NOP_OP;
            void'(exp_q.pop_back());
        end
    endtask

    initial begin
        int valid_seen;
        logic [7:0]  op;
        logic [31:0] a, b;

        // Reset state
        #3;
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;

        // Directed cases
        do_div(EXE_DIVU_OP, 32'd100, 32'd7, 0);
        do_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 0);
        do_div(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 0);
        do_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_div(EXE_DIVU_OP, 32'd5, 32'd0, 5);

        // Flush at cycle 10: IDLE at cycle 11, no result ever presented
        $display("issue: flush test DIV 1000/3");
        start(EXE_DIV_OP, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0; op_i = NOP_OP;
        @(negedge clk);
        check("flush_stall", {31'd0, stall_o}, 32'd0);
        valid_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) valid_seen++;
        end
        check("flush_no_valid", valid_seen, 0);

        do_div(EXE_DIVU_OP, 32'd9, 32'd3, 0);

        // Asynchronous reset mid-operation at cycle 20
        $display("issue: reset test DIV 100/7");
        start(EXE_DIV_OP, 32'd100, 32'd7);
        repeat (20) @(posedge clk);
        #3 resetn = 1'b0; op_i = NOP_OP;
        #1;
        check("arst_stall", {31'd0, stall_o}, 32'd0);
        check("arst_valid", {31'd0, valid_o}, 32'd0);
        check("arst_hi", hi_o, 32'd0);
        check("arst_lo", lo_o, 32'd0);
        @(posedge clk);
        #3 resetn = 1'b1;
        do_div(EXE_DIVU_OP, 32'd100, 32'd7, 0);

        // Randomized traffic
        for (int i = 0; i < 12; i++) begin
            op = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            do_div(op, a, b, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for the EX-stage DIV/DIVU path of the five-stage MIPS core. It decodes the 8-bit ALU control word produced in decode, runs a 32-step restoring divide on the operands, and holds the pipeline via `stall_o` while busy. It presents quotient/remainder for HI/LO write-back until the EX stage advances, and drops work on exception flush.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width.
- `CNT_W`, 5, iteration counter width (log2 WIDTH).

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `op_i`  in  8  EX-stage ALU control; `EXE_DIV_OP` = signed, `EXE_DIVU_OP` = unsigned, anything else = no request.
- `a_i`  in  WIDTH  dividend (rs), forwarded value.
- `b_i`  in  WIDTH  divisor (rt), forwarded value.
- `ack_i`  in  1  EX→MEM register advances this cycle.
- `flush_i`  in  1  exception/ERET flush of EX.
- `stall_o`  out  1  hold IF/ID/EX.
- `valid_o`  out  1  `hi_o`/`lo_o` hold a finished result.
- `hi_o`  out  WIDTH  remainder.
- `lo_o`  out  WIDTH  quotient.

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE; counter 0; `hi_o`=`lo_o`=0; `valid_o`=0; `stall_o`=0 whenever `op_i` is not a divide.
- `req` = (`op_i`==`EXE_DIV_OP` | `op_i`==`EXE_DIVU_OP`).
- IDLE & req & !flush_i:
  - latch |a|, |b| (abs only when signed), `qneg` = a[31]^b[31], `rneg` = a[31] (both 0 if unsigned), `bzero` = (b_i==0);
  - clear partial remainder; counter=0; → BUSY.
- BUSY: one restoring step per cycle, MSB first: rem = {rem, a_bit}; if rem ≥ |b| then rem -= |b| and qbit = 1, else qbit = 0. Counter increments; at counter==WIDTH-1 → DONE.
- Entering DONE, results are registered:
  - `bzero`: `lo_o`=32'hFFFFFFFF, `hi_o`=a_i as latched; no sign correction.
  - otherwise `lo_o` = qneg ? -q : q and `hi_o` = rneg ? -r : r, in two's complement mod 2^32.
  - 0x80000000 / 0xFFFFFFFF signed → lo=0x80000000, hi=0.
- DONE: `valid_o`=1. Outputs hold. On `ack_i` → IDLE. A still-asserted req in DONE without ack never restarts.
- `flush_i` in any state → IDLE next edge. `valid_o` is not asserted for flushed work; `hi_o`/`lo_o` keep their last values.
- `stall_o` = (IDLE & req & !flush_i) | BUSY. It is combinational from IDLE so the divide instruction never leaves EX on its first cycle.
- `resetn` low mid-operation: immediate IDLE, all registers to reset values.

## Timing
- Cycle 0: IDLE, req sampled, `stall_o`=1.
- Cycles 1–32: BUSY, `stall_o`=1.
- Cycle 33: DONE, `valid_o`=1, `stall_o`=0, results stable.
- Latency from request to valid is 33 cycles. Earliest ack is cycle 33; IDLE on cycle 34.
- Back-to-back divides: the second request is sampled the cycle after IDLE is re-entered.
- `ack_i` is ignored outside DONE. Flush has priority over ack in the same cycle. Either way the next state is IDLE.
- No combinational path from `a_i`/`b_i` to any output.

## Structure
- Shared defines header holds `EXE_DIV_OP`, `EXE_DIVU_OP` (existing ALU op codes) and the state encoding (`DIV_IDLE`=2'b00, `DIV_BUSY`=2'b01, `DIV_DONE`=2'b10).
- Sub-module `div_step`: combinational single restoring step. Inputs are rem, next dividend bit and divisor; outputs are the new rem and qbit.
- Top-level `div_seq` holds the FSM, counter, operand/sign registers and output correction.

## Test plan
- Unsigned: DIVU 100 / 7 → cycle 33 `valid_o`=1, lo=14, hi=2; `stall_o` high exactly cycles 0–32.
- Signed: DIV -7 / 2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 7 / -2 → lo=-3, hi=1.
- Corners:
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0;
  - DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5.
- Flush: assert `flush_i` at cycle 10 → IDLE at cycle 11, `stall_o`=0, `valid_o` never 1.
- Hold/ack: in DONE keep `ack_i`=0 for 5 cycles with `op_i` still DIV → outputs stable, no restart. Ack → IDLE; a new DIVU 9/3 → lo=3, hi=0 after 33 cycles.
- Reset: deassert `resetn` at cycle 20 → all outputs 0 asynchronously; after release, a new request completes normally.
